// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Decoupling FIFO sitting between instruction fetch and decode. Every entry
// carries one fetched instruction word together with its PC and PC+4. Fetch
// pushes with a valid/ready handshake and decode pops with a valid/ready
// handshake. A flush (branch/jump redirect) empties the queue in a single
// cycle so that wrong-path instructions never reach decode.
//
// Parameters:
//   DBITS  width of PC and instruction words
//   DEPTH  number of entries, power of two and at least 2
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   reset         asynchronous, active-low reset (clears pointers and count)
//   flush         synchronous discard of every queued entry
//   in_valid      fetch offers an entry
//   in_ready      queue can take an entry (registered state only)
//   in_pc         PC of the offered instruction
//   in_pc_added   PC+4 of the offered instruction
//   in_instr      offered instruction word
//   out_valid     head entry available to decode
//   out_ready     decode consumes the head entry
//   out_pc        head entry PC (0 while out_valid is low)
//   out_pc_added  head entry PC+4 (0 while out_valid is low)
//   out_instr     head entry instruction (0 while out_valid is low)
//   count         number of occupied entries
//
// Optional feature macro:
//   FETCHQ_BYPASS_EN  when defined, an offer arriving at an empty queue is
//                     passed straight through to decode in the same cycle.
//                     If decode takes it, it is never written into storage.
//                     When undefined, push-to-visible latency is one cycle.
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int DBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DBITS-1:0]           in_pc,
    input  logic [DBITS-1:0]           in_pc_added,
    input  logic [DBITS-1:0]           in_instr,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DBITS-1:0]           out_pc,
    output logic [DBITS-1:0]           out_pc_added,
    output logic [DBITS-1:0]           out_instr,

    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
    localparam logic [PTRW-1:0] PTR_ONE    = PTRW'(1);

    // Circular buffer storage, one array per field of the entry.
    logic [DBITS-1:0] pcMem      [DEPTH];
    logic [DBITS-1:0] pcAddedMem [DEPTH];
    logic [DBITS-1:0] instrMem   [DEPTH];

    logic [PTRW-1:0] rdPtr;
    logic [PTRW-1:0] wrPtr;

    logic queueEmpty;
    logic queueFull;
    logic doPush;
    logic doPop;
    logic bypassActive;
    logic bypassTaken;

    // Occupancy flags come from the registered count only, so in_ready never
    // depends on out_ready and a full queue refuses a push even when a pop
    // happens in the same cycle.
    always_comb begin
        queueEmpty = (count == '0);
        queueFull  = (count == FULL_COUNT);
        in_ready   = !queueFull;
    end

`ifdef FETCHQ_BYPASS_EN
    // Pass-through path: with nothing queued, the offered entry is shown to
    // decode immediately. A flush suppresses it because the offer belongs to
    // the wrong path.
    always_comb begin
        bypassActive = queueEmpty && in_valid && !flush;
        bypassTaken  = bypassActive && out_ready;
    end
`else
    // No pass-through path; every entry goes through storage.
    always_comb begin
        bypassActive = 1'b0;
        bypassTaken  = 1'b0;
    end
`endif

    // Handshake qualification. A flush drops a simultaneous push and ignores
    // a simultaneous pop. An entry consumed through the bypass is neither
    // written nor counted, so count stays at zero while streaming through an
    // empty queue.
    always_comb begin
        doPush = in_valid && in_ready && !flush && !bypassTaken;
        doPop  = !queueEmpty && out_ready && !flush;
    end

    // Decode-facing outputs. The head of storage wins whenever something is
    // queued, the bypass only shows while the queue is empty, and everything
    // is forced to zero when there is nothing to present. out_valid reflects
    // the pre-flush state during a flush cycle.
    always_comb begin
        out_valid    = 1'b0;
        out_pc       = '0;
        out_pc_added = '0;
        out_instr    = '0;
        if (!queueEmpty) begin
            out_valid    = 1'b1;
            out_pc       = pcMem[rdPtr];
            out_pc_added = pcAddedMem[rdPtr];
            out_instr    = instrMem[rdPtr];
        end else if (bypassActive) begin
            out_valid    = 1'b1;
            out_pc       = in_pc;
            out_pc_added = in_pc_added;
            out_instr    = in_instr;
        end
    end

    // Pointer and occupancy state. Flush takes priority over any handshake
    // and returns everything to the empty position; pointers wrap naturally
    // because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry storage has no reset; contents are only observed through rdPtr
    // while count says they are valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            pcMem[wrPtr]      <= in_pc;
            pcAddedMem[wrPtr] <= in_pc_added;
            instrMem[wrPtr]   <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue. A queue of entries models the FIFO:
// occupancy is its size, the head is its first element, a flush empties it.
// Inputs are applied on the falling edge, outputs are compared shortly after,
// and the model advances at the following rising edge.
// Honours FETCHQ_BYPASS_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int DBITS = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DBITS-1:0] pc;
        logic [DBITS-1:0] pcAdded;
        logic [DBITS-1:0] instr;
    } FetchEntry;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [DBITS-1:0] in_pc;
    logic [DBITS-1:0] in_pc_added;
    logic [DBITS-1:0] in_instr;
    logic             out_valid;
    logic             out_ready;
    logic [DBITS-1:0] out_pc;
    logic [DBITS-1:0] out_pc_added;
    logic [DBITS-1:0] out_instr;
    logic [CNTW-1:0]  count;

    FetchEntry model[$];
    int numChecks = 0;
    int numFails  = 0;

    fetch_queue #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_pc_added  (in_pc_added),
        .in_instr     (in_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_added (out_pc_added),
        .out_instr    (out_instr),
        .count        (count)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs (called on a falling edge), compare all
    // outputs against the model, then advance the model across the rising
    // edge and return on the next falling edge.
    task automatic applyStimulus(input logic fl, input logic iv,
                                 input logic [DBITS-1:0] pc,
                                 input logic [DBITS-1:0] pcA,
                                 input logic [DBITS-1:0] ins,
                                 input logic ordy);
        FetchEntry head;
        int  expCount;
        logic expReady, expValid, bypass, popping, pushing;

        flush       = fl;
        in_valid    = iv;
        in_pc       = pc;
        in_pc_added = pcA;
        in_instr    = ins;
        out_ready   = ordy;
        #1;

        expCount = model.size();
        expReady = (expCount != DEPTH);
        bypass   = 1'b0;
`ifdef FETCHQ_BYPASS_EN
        bypass   = (expCount == 0) && iv && !fl;
`endif
        expValid = (expCount != 0) || bypass;
        head     = '0;
        if (expCount != 0) begin
            head = model[0];
        end else if (bypass) begin
            head = '{pc: pc, pcAdded: pcA, instr: ins};
        end

        checkOutput("count",        64'(count),        64'(expCount));
        checkOutput("in_ready",     64'(in_ready),     64'(expReady));
        checkOutput("out_valid",    64'(out_valid),    64'(expValid));
        checkOutput("out_pc",       64'(out_pc),       64'(head.pc));
        checkOutput("out_pc_added", 64'(out_pc_added), 64'(head.pcAdded));
        checkOutput("out_instr",    64'(out_instr),    64'(head.instr));

        popping = expValid && ordy;
        pushing = iv && expReady;

        @(posedge clk);
        if (fl) begin
            model.delete();
        end else begin
            if (popping && expCount != 0) begin
                void'(model.pop_front());
            end
            if (pushing && !(bypass && ordy)) begin
                model.push_back('{pc: pc, pcAdded: pcA, instr: ins});
            end
        end
        @(negedge clk);
    endtask

    task automatic idleInputs();
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_pc_added = '0;
        in_instr    = '0;
        out_ready   = 1'b0;
    endtask

    // Top-level sequence: directed scenarios followed by a random soak.
    initial begin
        logic [DBITS-1:0] pc;

        idleInputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Values while held in reset.
        checkOutput("rst_count",     64'(count),     64'd0);
        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_pc",    64'(out_pc),    64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single push, then drain it.
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h44, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,        1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,        1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,        1'b0);

        // Fill to full, offer a fifth entry, then pop once.
        for (int i = 0; i < 5; i++) begin
            pc = 32'h40 + 32'(4 * i);
            applyStimulus(1'b0, 1'b1, pc, pc + 32'd4, 32'h1000 + 32'(i), 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 32'h54, 32'h58, 32'h2000, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h58, 32'h5C, 32'h2001, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,    1'b0);

        // Drain, then stream ten entries across the pointer wrap.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            pc = 32'h40 + 32'(4 * i);
            applyStimulus(1'b0, 1'b1, pc, pc + 32'd4, 32'h3000 + 32'(i), 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        end

        // Three queued, then flush together with a push of pc 0x80.
        for (int i = 0; i < 3; i++) begin
            pc = 32'h100 + 32'(4 * i);
            applyStimulus(1'b0, 1'b1, pc, pc + 32'd4, 32'h4000 + 32'(i), 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h84, 32'h5000, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,    1'b1);
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h204, 32'h6000, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0,  32'h0,  32'h0,    1'b1);

        // Asynchronous reset between clock edges with two entries queued.
        applyStimulus(1'b0, 1'b1, 32'h300, 32'h304, 32'h7000, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h304, 32'h308, 32'h7001, 1'b0);
        idleInputs();
        #1;
        checkOutput("pre_arst_count", 64'(count), 64'(model.size()));
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_count",     64'(count),     64'd0);
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("arst_out_pc",    64'(out_pc),    64'd0);
        model.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Random soak with occasional flushes.
        for (int i = 0; i < 1500; i++) begin
            logic fl, iv, ordy;
            logic [DBITS-1:0] rpc;
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 9) < 6);
            ordy = ($urandom_range(0, 9) < 5);
            rpc  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            applyStimulus(fl, iv, rpc, rpc + 32'd4, $urandom(), ordy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between instruction fetch and decode. Each entry holds one fetched instruction, its PC, and PC+4. Fetch pushes entries with a valid/ready handshake; decode pops them with a valid/ready handshake. A flush from branch/jump resolution discards every queued entry in one cycle, so wrong-path instructions never reach decode.

## Interface
- `DBITS`, 32, width of PC and instruction words
- `DEPTH`, 4, number of entries; power of two, ≥2

Ports:
- `clk`  input  1  clock; all state updates on rising edge
- `reset`  input  1  asynchronous, active-low reset
- `flush`  input  1  discard all entries; synchronous
- `in_valid`  input  1  fetch offers an entry
- `in_ready`  output  1  queue can accept an entry
- `in_pc`  input  DBITS  PC of the fetched instruction
- `in_pc_added`  input  DBITS  PC+4 of that instruction
- `in_instr`  input  DBITS  instruction word
- `out_valid`  output  1  head entry available to decode
- `out_ready`  input  1  decode consumes the head entry
- `out_pc`  output  DBITS  head entry PC
- `out_pc_added`  output  DBITS  head entry PC+4
- `out_instr`  output  DBITS  head entry instruction
- `count`  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Storage is a circular buffer with `rd_ptr` and `wr_ptr`, each log2(DEPTH) bits wide, plus `count`. Pointers wrap modulo DEPTH.
- Push when `in_valid && in_ready`: write the triple at `wr_ptr`, then increment `wr_ptr`.
- Pop when `out_valid && out_ready`: increment `rd_ptr`.
- `count` update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged
- `in_ready = (count != DEPTH)`. It depends on registered state only, never on `out_ready`.
  - A push into a full queue is impossible, even if a pop happens in the same cycle.
- `out_valid = (count != 0)`.
- `out_*` show the entry at `rd_ptr` while `out_valid` is high, and are driven to 0 while `out_valid` is low.
- `flush` has priority over everything else. On a flush cycle:
  - `rd_ptr`, `wr_ptr` and `count` all go to 0.
  - A simultaneous push is dropped and a simultaneous pop is ignored.
  - `in_ready`/`out_valid` as seen in that cycle still follow the pre-flush state, but no storage update happens.
- Reset (asserted low, at any time including mid-transfer) clears the pointers and `count` immediately. Storage contents are don't-care.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `count`=0, `out_pc`/`out_pc_added`/`out_instr`=0.
- Latency from push to `out_valid`: 1 cycle, i.e. an entry is visible the cycle after the push edge.
- Throughput: 1 entry/cycle with concurrent push and pop at any occupancy from 1 to DEPTH−1.
- When full, one pop frees `in_ready` the following cycle.
- Entries leave in strict push order; no reordering across the wrap-around.
- After a flush, the first new push can happen in the cycle immediately following it.

## Configuration
- `FETCHQ_BYPASS_EN`
  - **Defined:** when `count`==0 and `in_valid`=1 (and no `flush`), the input passes through combinationally.
    - `out_valid`=1 and `out_*`=`in_*` in the same cycle.
    - If `out_ready`=1 as well, the entry is consumed and not written; `count` stays 0.
    - If `out_ready`=0, the entry is written normally.
    - Zero-latency path when the queue is empty.
  - **Undefined:** no bypass path; latency is always 1 cycle as in Timing.

## Test plan
- **Reset:** release `reset` -> `in_ready`=1, `out_valid`=0, `count`=0, outputs 0.
- **Push and pop:** push pc=0x40, pc_added=0x44, instr=0xDEADBEEF with `out_ready`=0 -> next cycle `out_valid`=1 with those values, `count`=1; then `out_ready`=1 -> `count`=0 the cycle after.
- **Fill to full:** push 4 entries (pc 0x40, 0x44, 0x48, 0x4C) with `out_ready`=0 -> `count`=4, `in_ready`=0; a 5th offer is not accepted; pop once -> `in_ready`=1 the next cycle.
- **Streaming across wrap:** hold `in_valid`=`out_ready`=1 for 10 cycles with pc incrementing by 4 from 0x40 -> `out_pc` sequence 0x40…0x64 in order, `count` constant at 1 (0 with `FETCHQ_BYPASS_EN`).
- **Flush:** with 3 entries queued, assert `flush` together with a push of pc=0x80 -> next cycle `count`=0 and `out_valid`=0; pc=0x80 is never output.
- **Async reset mid-stream:** assert `reset` low between clock edges with `count`=2 -> `count`=0 and `out_valid`=0 immediately, without waiting for `clk`.
